// File: rtl/alu_muldiv_if.sv
// Start/busy/done bus between the execute stage and the multiply/divide unit.
// The execute stage drives operands; the unit returns the HI/LO pair.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             iStart;
    logic             iOp;
    logic             iSign;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oBusy;
    logic             oDone;
    logic [WIDTH-1:0] oHi;
    logic [WIDTH-1:0] oLo;
    logic             oDivZero;

    modport master (
        output iStart, iOp, iSign, iA, iB,
        input  oBusy, oDone, oHi, oLo, oDivZero
    );

    modport slave (
        input  iStart, iOp, iSign, iA, iB,
        output oBusy, oDone, oHi, oLo, oDivZero
    );
endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit, one bit per cycle, HI/LO result.
// Works on operand magnitudes and applies sign correction in a final cycle.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic iClk,
    input  logic iReset,
    alu_muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] resHi;
    logic [WIDTH-1:0] resLo;
    logic             isDiv;
    logic             negRes;
    logic             negRem;
    logic             bZero;
    logic             divZero;

    logic             accept;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   remShift;
    logic [WIDTH-1:0] remDiff;
    logic             remGe;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fixHi;
    logic [WIDTH-1:0] fixLo;

    assign accept = bus.iStart && (state == IDLE || state == DONE);

    assign magA = (bus.iSign && bus.iA[WIDTH-1]) ? -bus.iA : bus.iA;
    assign magB = (bus.iSign && bus.iB[WIDTH-1]) ? -bus.iB : bus.iB;

    // Multiply: add multiplicand when the current multiplier bit is set,
    // then shift the whole 2*WIDTH accumulator right with the carry.
    assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);

    // Divide: shift the next dividend bit into the partial remainder.
    assign remShift = {accHi, accLo[WIDTH-1]};
    assign remGe    = remShift >= {1'b0, opB};
    assign remDiff  = remShift[WIDTH-1:0] - opB;

    assign prod = negRes ? -{accHi, accLo} : {accHi, accLo};

    always_comb begin
        fixHi = prod[2*WIDTH-1:WIDTH];
        fixLo = prod[WIDTH-1:0];
        if (isDiv) begin
            fixLo = negRes ? -accLo : accLo;
            // Zero divisor leaves |A| in the remainder, so this restores A.
            fixHi = negRem ? -accHi : accHi;
            if (bZero) begin
                fixLo = '1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (accept) stateNext = CALC;
            CALC: if (cnt == '0) stateNext = FIX;
            FIX:  stateNext = DONE;
            DONE: stateNext = accept ? CALC : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            cnt     <= '0;
            accHi   <= '0;
            accLo   <= '0;
            opB     <= '0;
            resHi   <= '0;
            resLo   <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            bZero   <= 1'b0;
            divZero <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_W'(WIDTH - 1);
            accHi   <= '0;
            accLo   <= magA;
            opB     <= magB;
            isDiv   <= bus.iOp;
            negRes  <= bus.iSign & (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]);
            negRem  <= bus.iSign & bus.iA[WIDTH-1];
            bZero   <= (bus.iB == '0);
            divZero <= 1'b0;
        end else if (state == CALC) begin
            cnt <= cnt - 1'b1;
            if (isDiv) begin
                accHi <= remGe ? remDiff : remShift[WIDTH-1:0];
                accLo <= {accLo[WIDTH-2:0], remGe};
            end else begin
                accHi <= mulSum[WIDTH:1];
                accLo <= {mulSum[0], accLo[WIDTH-1:1]};
            end
        end else if (state == FIX) begin
            resHi   <= fixHi;
            resLo   <= fixLo;
            divZero <= isDiv & bZero;
        end
    end

    assign bus.oBusy    = (state == CALC) || (state == FIX);
    assign bus.oDone    = (state == DONE);
    assign bus.oHi      = resHi;
    assign bus.oLo      = resLo;
    assign bus.oDivZero = divZero;
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit that sits beside the combinational ALU in the execute stage.
- Executes MIPS MULT/MULTU/DIV/DIVU and produces the HI/LO pair.
- Operates on WIDTH-bit operands with signed/unsigned select, iterating one bit per cycle.
- Uses a start/busy/done handshake so the pipeline can stall on it.

Parameters:
- WIDTH, 32: operand width in bits. Must be ≥ 4.
- CNT_W, $clog2(WIDTH)+1: width of the iteration counter. Derived; do not override.

Ports:
- iClk  in  1  clock
- iReset  in  1  synchronous, active-high reset
- iStart  in  1  request a new operation; sampled only when the unit can accept
- iOp  in  1  0 = multiply, 1 = divide
- iSign  in  1  1 = signed (two's complement), 0 = unsigned
- iA  in  WIDTH  multiplicand / dividend
- iB  in  WIDTH  multiplier / divisor
- oBusy  out  1  operation in progress; iStart is ignored while high
- oDone  out  1  one-cycle pulse; results valid from this cycle
- oHi  out  WIDTH  multiply: upper product half; divide: remainder
- oLo  out  WIDTH  multiply: lower product half; divide: quotient
- oDivZero  out  1  last divide had iB == 0; valid with oDone, held until the next accept

Behaviour:
- Clock and reset: one clock (iClk). Reset is synchronous, active-high on iReset.
- Reset values:
  - state = IDLE
  - oBusy = 0, oDone = 0, oDivZero = 0
  - oHi = 0, oLo = 0
- Reset mid-operation aborts the operation immediately. oHi/oLo are cleared, not left holding stale results.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE or DONE with iStart = 1 → CALC on that edge (the accept edge).
  - iA, iB, iOp and iSign are latched at the accept edge. Later changes on those inputs have no effect.
  - Signed mode latches operand magnitudes plus the sign bits. Unsigned mode uses operands as-is.
  - Counter loads WIDTH-1.
  - oDivZero is cleared at accept.
- CALC performs one iteration per cycle and decrements the counter.
  - Multiply: shift-add over 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - At counter = 0 → FIX. CALC therefore lasts exactly WIDTH cycles.
- FIX (1 cycle) applies sign correction, then → DONE.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- DONE: oDone = 1 for exactly this cycle. oHi/oLo/oDivZero update on the edge entering DONE.
  - With iStart = 0 → IDLE.
  - With iStart = 1 → CALC (back-to-back accept, no bubble).
- Timing relative to the accept edge at cycle k:
  - oBusy is high in cycles k+1 … k+WIDTH+1 (CALC and FIX).
  - oDone is high in cycle k+WIDTH+2.
  - oBusy is low in IDLE and DONE.
- iStart while oBusy = 1 is ignored and not queued.
- oHi/oLo hold their last result until the next DONE or reset.
- Multiply is exact at 2·WIDTH bits: {oHi,oLo} = A·B. There is no overflow flag.
- Divide by zero (iB = 0), signed or unsigned:
  - Latency is unchanged.
  - oDivZero = 1, oLo = all ones, oHi = the original iA (sign-correct, no negation).
- Signed overflow case (-2^(WIDTH-1) / -1): quotient wraps to -2^(WIDTH-1), remainder 0, no flag.
- The unit has no iOp-dependent latency: multiply and divide both take WIDTH+2 cycles from accept to oDone.

Test Plan:
- Latency and unsigned multiply (WIDTH=32): unsigned 7 × 8, accept at cycle k → oBusy high for 33 cycles, oDone high only at k+34, oHi = 0, oLo = 56. Also 0xFFFFFFFF × 0xFFFFFFFF unsigned → oHi = 0xFFFFFFFE, oLo = 0x00000001.
- Signed multiply: -2 × 3 → oHi = 0xFFFFFFFF, oLo = 0xFFFFFFFA. Same operands unsigned → oHi = 0x00000002, oLo = 0xFFFFFFFA.
- Divide: unsigned 100 / 7 → oLo = 14, oHi = 2. Signed -7 / 2 → oLo = 0xFFFFFFFD, oHi = 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF → oLo = 0x80000000, oHi = 0.
- Divide by zero: 5 / 0 signed → oDivZero = 1, oLo = 0xFFFFFFFF, oHi = 5, oDone at k+34. A following 6 / 3 → oDivZero = 0, oLo = 2.
- Handshake:
  - iStart pulsed at k+5 during busy with different operands → ignored; the first result is unchanged.
  - iStart held high through DONE → second op accepted that edge; its oDone at exactly 34 cycles later.
- Reset mid-op: iReset at k+10 → next cycle oBusy = 0, oDone = 0, oHi = oLo = 0. A new 3 × 4 afterwards → oLo = 12 with normal latency.
